servo_motion_scheduler: RTL and testbench



---
 rtl/servo_motion_scheduler_pkg.sv | 32 +++
 rtl/servo_motion_scheduler_if.sv | 14 +
 rtl/servo_rr_arbiter.sv | 86 ++++++++
 rtl/servo_motion_scheduler.sv | 104 ++++++++++
 tb/tb_servo_motion_scheduler.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/servo_motion_scheduler_pkg.sv
// Shared constants, arbiter state type and channel-index helpers
// for the three-channel servo motion scheduler.
package servo_pkg;
  localparam int N_CH          = 3;
  localparam int FRAME_CYC_DEF = 1000000;
  localparam int PW_MIN_DEF    = 50000;
  localparam int PW_MAX_DEF    = 100000;
  localparam int STEP_DEF      = 1000;
  localparam int CNT_W_DEF     = 20;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_e;
  typedef logic [1:0] ch_idx_t;

  // Next channel in round-robin order, wrapping 2 -> 0.
  function automatic ch_idx_t ch_next(input ch_idx_t c);
    ch_idx_t n;
    if (c == 2'd2) n = 2'd0;
    else n = c + 2'd1;
    return n;
  endfunction

  function automatic logic [N_CH-1:0] ch_onehot(input ch_idx_t c);
    logic [N_CH-1:0] oh;
    case (c)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction
endpackage

// File: rtl/servo_motion_scheduler_if.sv
// Board-side bundle of the scheduler: switch inputs, indicator LEDs,
// servo header pins and motion status.
interface servo_motion_scheduler_if
  import servo_pkg::*;
();
  logic [N_CH-1:0] toggle;
  logic [N_CH-1:0] led;
  logic [N_CH-1:0] servo;
  logic [N_CH-1:0] grant;
  logic            busy;

  modport master (output toggle, input led, input servo, input grant, input busy);
  modport slave  (input toggle, output led, output servo, output grant, output busy);
endinterface

// File: rtl/servo_rr_arbiter.sv
// Round-robin motion permission: grants one pending channel per frame
// decision and holds it until that channel reaches its target.
module servo_rr_arbiter
  import servo_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pend,
  input  logic            frame_tick,
  output logic [N_CH-1:0] grant
);
  arb_state_e      state_r, state_s;
  ch_idx_t         idx_r, idx_s, ptr_r, ptr_s;
  ch_idx_t         base_s, scan_s, pick_s;
  logic            found_s, cur_pend_s;
  logic [N_CH-1:0] grant_r, grant_s;

  // Selection scan starts after a finishing channel, otherwise at the pointer.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    ptr_s      = ptr_r;
    found_s    = 1'b0;
    pick_s     = ptr_r;
    cur_pend_s = |(pend & ch_onehot(idx_r));
    if ((state_r == ARB_GRANT) && !cur_pend_s) base_s = ch_next(idx_r);
    else base_s = ptr_r;
    scan_s = base_s;
    for (int j = 0; j < N_CH; j++) begin
      if (!found_s && (|(pend & ch_onehot(scan_s)))) begin
        found_s = 1'b1;
        pick_s  = scan_s;
      end else begin
        found_s = found_s;
      end
      scan_s = ch_next(scan_s);
    end
    if (frame_tick) begin
      case (state_r)
        ARB_IDLE: begin
          if (found_s) begin
            state_s = ARB_GRANT;
            idx_s   = pick_s;
          end else begin
            state_s = ARB_IDLE;
          end
        end
        ARB_GRANT: begin
          if (cur_pend_s) begin
            state_s = ARB_GRANT;
          end else begin
            ptr_s = base_s;
            if (found_s) begin
              state_s = ARB_GRANT;
              idx_s   = pick_s;
            end else begin
              state_s = ARB_IDLE;
            end
          end
        end
        default: state_s = ARB_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
    if (state_s == ARB_GRANT) grant_s = ch_onehot(idx_s);
    else grant_s = 3'b000;
  end

  // Arbiter state, granted index, pointer and registered grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
      idx_r   <= 2'd0;
      ptr_r   <= 2'd0;
      grant_r <= 3'b000;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      ptr_r   <= ptr_s;
      grant_r <= grant_s;
    end
  end

  assign grant = grant_r;
endmodule

// File: rtl/servo_motion_scheduler.sv
// Three-servo PWM driver on one shared frame counter; targets flip on switch
// edges and widths slew one step per frame for the single granted channel.
module servo_motion_scheduler
  import servo_pkg::*;
#(
  parameter int FRAME_CYC = FRAME_CYC_DEF,
  parameter int PW_MIN    = PW_MIN_DEF,
  parameter int PW_MAX    = PW_MAX_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic                    mclk,
  input logic                    rst_n,
  servo_motion_scheduler_if.slave bus
);
  localparam logic [CNT_W-1:0] FRAME_LAST_C = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0] PW_MIN_C     = CNT_W'(PW_MIN);
  localparam logic [CNT_W-1:0] PW_MAX_C     = CNT_W'(PW_MAX);
  localparam logic [CNT_W-1:0] STEP_C       = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             frame_tick_s;
  logic [N_CH-1:0]  sync1_r, sync2_r, prev_r, rise_s, target_r;
  logic [N_CH-1:0]  pend_s, grant_s, servo_r;
  logic             busy_r;
  logic [CNT_W-1:0] pw_r   [N_CH];
  logic [CNT_W-1:0] pw_s   [N_CH];
  logic [CNT_W-1:0] goal_s [N_CH];

  assign frame_tick_s = (cnt_r == FRAME_LAST_C);
  assign rise_s       = sync2_r & ~prev_r;

  // Shared frame counter.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) cnt_r <= '0;
    else if (frame_tick_s) cnt_r <= '0;
    else cnt_r <= cnt_r + CNT_ONE_C;
  end

  // Switch synchronizer; prev_r makes a held switch count as a single edge.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 3'b000;
      sync2_r  <= 3'b000;
      prev_r   <= 3'b000;
      target_r <= 3'b000;
    end else begin
      sync1_r  <= bus.toggle;
      sync2_r  <= sync1_r;
      prev_r   <= sync2_r;
      target_r <= target_r ^ rise_s;
    end
  end

  // Pending detection and clamped one-step slew for the granted channel.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      if (target_r[i]) goal_s[i] = PW_MAX_C;
      else goal_s[i] = PW_MIN_C;
      pend_s[i] = (pw_r[i] != goal_s[i]);
      pw_s[i]   = pw_r[i];
      if (frame_tick_s && grant_s[i] && pend_s[i]) begin
        if (target_r[i]) begin
          if (pw_r[i] >= (PW_MAX_C - STEP_C)) pw_s[i] = PW_MAX_C;
          else pw_s[i] = pw_r[i] + STEP_C;
        end else begin
          if (pw_r[i] <= (PW_MIN_C + STEP_C)) pw_s[i] = PW_MIN_C;
          else pw_s[i] = pw_r[i] - STEP_C;
        end
      end else begin
        pw_s[i] = pw_r[i];
      end
    end
  end

  // Widths only change on frame_tick, so every pulse starts at a frame boundary.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) pw_r[i] <= PW_MIN_C;
      servo_r <= 3'b000;
      busy_r  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        pw_r[i]    <= pw_s[i];
        servo_r[i] <= (cnt_r < pw_r[i]);
      end
      busy_r <= |pend_s;
    end
  end

  servo_rr_arbiter u_arb (
    .clk        (mclk),
    .rst_n      (rst_n),
    .pend       (pend_s),
    .frame_tick (frame_tick_s),
    .grant      (grant_s)
  );

  assign bus.led   = target_r;
  assign bus.servo = servo_r;
  assign bus.grant = grant_s;
  assign bus.busy  = busy_r;
endmodule

// File: tb/tb_servo_motion_scheduler.sv
// Frame-level bench: a monitor measures each channel's pulse width per frame,
// and expected frame records are queued as stimulus is applied.
module tb_servo_motion_scheduler;
  import servo_pkg::*;

  localparam int FRAME   = 100;
  localparam int PH_SNAP = 50;
  localparam int N_TBL   = 27;

  typedef struct {
    logic       rst;
    logic [2:0] tog;
    int         w0, w1, w2;
    logic [2:0] grant, led;
    logic       busy;
  } vec_t;

  typedef struct {
    int         w0, w1, w2;
    logic [2:0] grant, led;
    logic       busy;
  } frame_t;

  logic   mclk  = 1'b0;
  logic   rst_n = 1'b1;
  int     errors = 0;
  int     checks = 0;
  int     ph = 0;
  int     hi [3];
  int     onehot_bad = 0;
  frame_t exp_q[$];
  frame_t got_q[$];
  vec_t   tbl [N_TBL];

  servo_motion_scheduler_if bus();

  servo_motion_scheduler #(
    .FRAME_CYC (100),
    .PW_MIN    (10),
    .PW_MAX    (20),
    .STEP      (4),
    .CNT_W     (7)
  ) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 mclk = ~mclk;

  // Pulse-width monitor: one record per frame, taken mid-frame after all pulses end.
  initial begin
    frame_t f;
    forever begin
      @(negedge mclk);
      if (!rst_n) begin
        ph = 0;
        for (int i = 0; i < 3; i++) hi[i] = 0;
      end else begin
        ph++;
        for (int i = 0; i < 3; i++) if (bus.servo[i]) hi[i]++;
        if ($countones(bus.grant) > 1) onehot_bad++;
        if ((ph % FRAME) == PH_SNAP) begin
          f.w0 = hi[0]; f.w1 = hi[1]; f.w2 = hi[2];
          f.grant = bus.grant; f.led = bus.led; f.busy = bus.busy;
          got_q.push_back(f);
          for (int i = 0; i < 3; i++) hi[i] = 0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic reset_dut(input string tag);
    rst_n = 1'b0;
    bus.toggle = 3'b000;
    #1;
    check({tag, ".servo_async"}, int'(bus.servo), 0);
    repeat (3) @(negedge mclk);
    #1;
    got_q.delete();
    exp_q.delete();
    check({tag, ".servo"}, int'(bus.servo), 0);
    check({tag, ".grant"}, int'(bus.grant), 0);
    check({tag, ".led"},   int'(bus.led),   0);
    check({tag, ".busy"},  int'(bus.busy),  0);
    rst_n = 1'b1;
  endtask

  task automatic frame_step(input string tag, input logic [2:0] tog,
                            input int w0, input int w1, input int w2,
                            input logic [2:0] g, input logic [2:0] led, input logic b);
    frame_t e, a;
    int waited;
    bus.toggle = tog;
    e.w0 = w0; e.w1 = w1; e.w2 = w2; e.grant = g; e.led = led; e.busy = b;
    exp_q.push_back(e);
    waited = 0;
    while ((got_q.size() == 0) && (waited < 3 * FRAME)) begin
      @(negedge mclk);
      #1;
      waited++;
    end
    e = exp_q.pop_front();
    if (got_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.frame_timeout: got no frame record after %0d cycles", tag, waited);
    end else begin
      a = got_q.pop_front();
      check({tag, ".w0"},    a.w0, e.w0);
      check({tag, ".w1"},    a.w1, e.w1);
      check({tag, ".w2"},    a.w2, e.w2);
      check({tag, ".grant"}, int'(a.grant), int'(e.grant));
      check({tag, ".led"},   int'(a.led),   int'(e.led));
      check({tag, ".busy"},  int'(a.busy),  int'(e.busy));
    end
  endtask

  initial begin
    // rst, toggle level for the frame, widths, grant, led, busy
    tbl[0]  = '{1'b0, 3'b000, 10, 10, 10, 3'b000, 3'b000, 1'b0};
    tbl[1]  = '{1'b0, 3'b000, 10, 10, 10, 3'b000, 3'b000, 1'b0};
    tbl[2]  = '{1'b0, 3'b001, 10, 10, 10, 3'b001, 3'b001, 1'b1};
    tbl[3]  = '{1'b0, 3'b000, 14, 10, 10, 3'b001, 3'b001, 1'b1};
    tbl[4]  = '{1'b0, 3'b000, 18, 10, 10, 3'b001, 3'b001, 1'b1};
    tbl[5]  = '{1'b0, 3'b000, 20, 10, 10, 3'b001, 3'b001, 1'b0};
    tbl[6]  = '{1'b0, 3'b000, 20, 10, 10, 3'b000, 3'b001, 1'b0};
    tbl[7]  = '{1'b0, 3'b010, 20, 10, 10, 3'b010, 3'b011, 1'b1};
    tbl[8]  = '{1'b0, 3'b010, 20, 14, 10, 3'b010, 3'b011, 1'b1};
    tbl[9]  = '{1'b0, 3'b010, 20, 18, 10, 3'b010, 3'b011, 1'b1};
    tbl[10] = '{1'b0, 3'b010, 20, 20, 10, 3'b010, 3'b011, 1'b0};
    tbl[11] = '{1'b0, 3'b010, 20, 20, 10, 3'b000, 3'b011, 1'b0};
    tbl[12] = '{1'b0, 3'b000, 20, 20, 10, 3'b000, 3'b011, 1'b0};
    tbl[13] = '{1'b1, 3'b000, 10, 10, 10, 3'b000, 3'b000, 1'b0};
    tbl[14] = '{1'b0, 3'b111, 10, 10, 10, 3'b001, 3'b111, 1'b1};
    tbl[15] = '{1'b0, 3'b000, 14, 10, 10, 3'b001, 3'b111, 1'b1};
    tbl[16] = '{1'b0, 3'b000, 18, 10, 10, 3'b001, 3'b111, 1'b1};
    tbl[17] = '{1'b0, 3'b000, 20, 10, 10, 3'b001, 3'b111, 1'b1};
    tbl[18] = '{1'b0, 3'b000, 20, 10, 10, 3'b010, 3'b111, 1'b1};
    tbl[19] = '{1'b0, 3'b000, 20, 14, 10, 3'b010, 3'b111, 1'b1};
    tbl[20] = '{1'b0, 3'b000, 20, 18, 10, 3'b010, 3'b111, 1'b1};
    tbl[21] = '{1'b0, 3'b000, 20, 20, 10, 3'b010, 3'b111, 1'b1};
    tbl[22] = '{1'b0, 3'b000, 20, 20, 10, 3'b100, 3'b111, 1'b1};
    tbl[23] = '{1'b0, 3'b000, 20, 20, 14, 3'b100, 3'b111, 1'b1};
    tbl[24] = '{1'b0, 3'b000, 20, 20, 18, 3'b100, 3'b111, 1'b1};
    tbl[25] = '{1'b0, 3'b000, 20, 20, 20, 3'b100, 3'b111, 1'b0};
    tbl[26] = '{1'b0, 3'b000, 20, 20, 20, 3'b000, 3'b111, 1'b0};

    bus.toggle = 3'b000;
    #1;
    reset_dut("rst0");
    for (int r = 0; r < N_TBL; r++) begin
      if (tbl[r].rst) reset_dut($sformatf("tbl%0d.rst", r));
      frame_step($sformatf("tbl%0d", r), tbl[r].tog, tbl[r].w0, tbl[r].w1, tbl[r].w2,
                 tbl[r].grant, tbl[r].led, tbl[r].busy);
    end

    // Edge-to-led latency, reversal during own ramp, cancelled pending move.
    reset_dut("rstC");
    frame_step("c0", 3'b000, 10, 10, 10, 3'b000, 3'b000, 1'b0);
    bus.toggle = 3'b001;
    repeat (2) @(negedge mclk);
    check("lat.cycle2", int'(bus.led), 0);
    @(negedge mclk);
    check("lat.cycle3", int'(bus.led), 1);
    #1;
    frame_step("c1", 3'b001, 10, 10, 10, 3'b001, 3'b001, 1'b1);
    frame_step("c2", 3'b000, 14, 10, 10, 3'b001, 3'b001, 1'b1);
    frame_step("c3", 3'b001, 10, 10, 10, 3'b001, 3'b000, 1'b0);
    frame_step("c4", 3'b000, 10, 10, 10, 3'b000, 3'b000, 1'b0);
    frame_step("c5", 3'b110, 10, 10, 10, 3'b010, 3'b110, 1'b1);
    frame_step("c6", 3'b000, 10, 14, 10, 3'b010, 3'b110, 1'b1);
    frame_step("c7", 3'b100, 10, 18, 10, 3'b010, 3'b010, 1'b1);
    frame_step("c8", 3'b000, 10, 20, 10, 3'b010, 3'b010, 1'b0);
    frame_step("c9", 3'b000, 10, 20, 10, 3'b000, 3'b010, 1'b0);

    // Reset while channel 0 is mid-ramp at width 18 with all pins high.
    reset_dut("rstD");
    frame_step("d0", 3'b000, 10, 10, 10, 3'b000, 3'b000, 1'b0);
    frame_step("d1", 3'b001, 10, 10, 10, 3'b001, 3'b001, 1'b1);
    frame_step("d2", 3'b000, 14, 10, 10, 3'b001, 3'b001, 1'b1);
    repeat (55) @(negedge mclk);
    #1;
    check("d.servo_high", int'(bus.servo), 7);
    #2;
    reset_dut("rstD2");
    frame_step("d3", 3'b000, 10, 10, 10, 3'b000, 3'b000, 1'b0);
    frame_step("d4", 3'b000, 10, 10, 10, 3'b000, 3'b000, 1'b0);

    check("grant_onehot_violations", onehot_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
